fnd_controller: RTL and testbench
=================================

FND_CONTROLLER -- requirements
Module: fnd_controller

Interface
REQ-001 Parameter REFRESH_DIV, default 100000, clock cycles per digit scan slot (1 kHz slot rate at 100 MHz); legal range 2 and up.
REQ-002 Parameter BLANK_LZ, default 1; when 1, leading zero digits are blanked.
REQ-003 clk  input  1  single clock for the whole block; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 value  input  14  binary count from the 4-digit counter; valid range 0..9999.
REQ-006 seg  output  8  active-low segment drive {dp,g,f,e,d,c,b,a}; registered.
REQ-007 an  output  4  active-low digit enable, one-hot-low; an[0] is the ones digit (rightmost); registered.
REQ-008 bcd  output  16  packed BCD of the displayed value {thousands,hundreds,tens,ones}; registered.

Function
REQ-009 Converter FSM states: IDLE, SHIFT, DONE; no other states reachable.
REQ-010 IDLE: sample value into the shift register, saturating to 9999 if value > 9999; clear the BCD scratch; next state SHIFT. IDLE lasts exactly 1 cycle.
REQ-011 SHIFT: serial double-dabble, 14 cycles; each cycle adds 3 to any scratch nibble >= 5, then shifts the whole register left 1 bit; next state DONE after the 14th shift.
REQ-012 DONE: copy scratch to bcd in a single cycle; next state IDLE. The conversion period is therefore fixed at 16 cycles, free-running.
REQ-013 value changes during SHIFT or DONE are ignored until the next IDLE sample; bcd never shows a partially converted or mixed value.
REQ-014 Latency: a value stable on the IDLE sample edge appears on bcd at most 16 cycles later. A change just after an IDLE sample appears at most 32 cycles later.
REQ-015 Scan prescaler counts 0..REFRESH_DIV-1 and wraps. At terminal count, digit index 0..3 increments and wraps 3->0.
REQ-016 an = 4'b1110, 4'b1101, 4'b1011, 4'b0111 for index 0..3 respectively. Exactly one bit is low at any time out of reset.
REQ-017 seg encodes the selected bcd nibble as follows, with dp always 1:
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90 (hex).
  - Nibble values 10..15 are unreachable; if present they drive FF.
REQ-018 Leading-zero blanking: with BLANK_LZ=1, digit k (k=1..3) drives seg=FF when nibbles k..3 are all zero. Digit 0 is never blanked. Internal zeros are shown.
REQ-019 seg and an are registered together, so a digit's segments and its enable change on the same edge with no cross-digit glitch.

Reset
REQ-020 While rst=1, all of the following hold immediately, regardless of clock:
  - FSM = IDLE, prescaler = 0, digit index = 0.
  - bcd = 16'h0000, seg = 8'hFF, an = 4'b1111.
REQ-021 On the first clock edge after rst falls:
  - an = 4'b1110 and seg = C0 (digit 0 of bcd 0000).
  - The FSM performs its IDLE sample on that same edge.
REQ-022 Reset asserted mid-conversion aborts the conversion with no bcd update. Conversion restarts from IDLE after release.

Verification
REQ-023 Reset, value=0, REFRESH_DIV=4 -> bcd=0000. an steps 1110,1101,1011,0111 every 4 cycles. seg=C0 on digit 0 and FF on digits 1..3.
REQ-024 value=1234, REFRESH_DIV=4 -> bcd=16'h1234 within 16 cycles. Per digit 0..3, seg = 99, B0, A4, F9.
REQ-025 value=405 -> bcd=16'h0405. Digit 3 seg=FF; digits 2,1,0 seg = 99, C0, 92. With BLANK_LZ=0, digit 3 seg=C0.
REQ-026 value=12000 and value=16383 -> bcd=16'h9999; all digits seg=90.
REQ-027 value switched 1111->2222 on the 5th SHIFT cycle -> next DONE writes 1111. The following DONE writes 2222. No other bcd value appears in between.
REQ-028 rst pulsed during SHIFT with bcd=16'h1234 -> asynchronously bcd=0000, seg=FF, an=1111. After release, bcd holds 0000 until the first full conversion completes.

Source files
------------

// File: rtl/fnd_controller.sv
// Four-digit seven-segment display controller.
// Serial double-dabble BCD conversion plus a multiplexed digit scanner.
module fnd_controller #(
    parameter int REFRESH_DIV = 100000,
    parameter bit BLANK_LZ    = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [13:0] value,
    output logic [7:0]  seg,
    output logic [3:0]  an,
    output logic [15:0] bcd
);

    localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] PRE_TC = PW'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t      state, state_nx;
    logic [29:0] sr, sr_nx, adj;
    logic [3:0]  cnt, cnt_nx;
    logic [15:0] bcd_nx;
    logic [13:0] sat;

    logic [PW-1:0] pre;
    logic [1:0]    idx;
    logic [3:0]    nib;
    logic          blank;
    logic [7:0]    seg_nx;

    assign sat = (value > 14'd9999) ? 14'd9999 : value;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            sr    <= '0;
            cnt   <= '0;
            bcd   <= '0;
        end else begin
            state <= state_nx;
            sr    <= sr_nx;
            cnt   <= cnt_nx;
            bcd   <= bcd_nx;
        end
    end

    // Scratch BCD lives in sr[29:14], binary operand in sr[13:0].
    always_comb begin
        state_nx = state;
        sr_nx    = sr;
        cnt_nx   = cnt;
        bcd_nx   = bcd;
        adj      = sr;
        unique case (state)
            IDLE: begin
                sr_nx    = {16'h0000, sat};
                cnt_nx   = '0;
                state_nx = SHIFT;
            end
            SHIFT: begin
                for (int i = 0; i < 4; i++) begin
                    if (sr[14+4*i +: 4] >= 4'd5)
                        adj[14+4*i +: 4] = sr[14+4*i +: 4] + 4'd3;
                end
                sr_nx  = {adj[28:0], 1'b0};
                cnt_nx = cnt + 4'd1;
                if (cnt == 4'd13)
                    state_nx = DONE;
            end
            DONE: begin
                bcd_nx   = sr[29:14];
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre <= '0;
            idx <= '0;
        end else if (pre == PRE_TC) begin
            pre <= '0;
            idx <= idx + 2'd1;
        end else begin
            pre <= pre + 1'b1;
        end
    end

    assign nib   = bcd[{idx, 2'b00} +: 4];
    assign blank = BLANK_LZ && (idx != 2'd0)
                   && ((bcd >> {idx, 2'b00}) == 16'h0000);

    always_comb begin
        seg_nx = 8'hFF;
        if (!blank) begin
            unique case (nib)
                4'd0:    seg_nx = 8'hC0;
                4'd1:    seg_nx = 8'hF9;
                4'd2:    seg_nx = 8'hA4;
                4'd3:    seg_nx = 8'hB0;
                4'd4:    seg_nx = 8'h99;
                4'd5:    seg_nx = 8'h92;
                4'd6:    seg_nx = 8'h82;
                4'd7:    seg_nx = 8'hF8;
                4'd8:    seg_nx = 8'h80;
                4'd9:    seg_nx = 8'h90;
                default: seg_nx = 8'hFF;
            endcase
        end
    end

    // Segments and enable share one register stage to avoid ghosting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg <= 8'hFF;
            an  <= 4'b1111;
        end else begin
            seg <= seg_nx;
            an  <= ~(4'b0001 << idx);
        end
    end

endmodule

// File: tb/tb_fnd_controller.sv
// Directed bench for fnd_controller: vector table plus reset and
// mid-conversion sequences, with blanking on and off.
module tb_fnd_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic [13:0] value;
    logic [7:0]  seg_a, seg_b;
    logic [3:0]  an_a, an_b;
    logic [15:0] bcd_a, bcd_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fnd_controller #(.REFRESH_DIV(4), .BLANK_LZ(1'b1)) dut_a (
        .clk(clk), .rst(rst), .value(value),
        .seg(seg_a), .an(an_a), .bcd(bcd_a)
    );

    fnd_controller #(.REFRESH_DIV(4), .BLANK_LZ(1'b0)) dut_b (
        .clk(clk), .rst(rst), .value(value),
        .seg(seg_b), .an(an_b), .bcd(bcd_b)
    );

    typedef struct {
        logic [13:0]     v;
        logic [15:0]     b;
        logic [3:0][7:0] sa;
        logic [3:0][7:0] sb;
    } vec_t;

    vec_t vt[8];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic wait_bcd(input logic [15:0] exp);
        for (int i = 0; i < 40; i++) begin
            if (bcd_a == exp) break;
            @(negedge clk);
        end
        chk("bcd_a", {16'h0, bcd_a}, {16'h0, exp});
        chk("bcd_b", {16'h0, bcd_b}, {16'h0, exp});
    endtask

    task automatic wait_an(input logic [3:0] exp);
        for (int i = 0; i < 20; i++) begin
            if (an_a == exp) break;
            @(negedge clk);
        end
        chk("an_scan", {28'h0, an_a}, {28'h0, exp});
    endtask

    initial begin
        vt[0] = '{14'd0,     16'h0000, {8'hFF, 8'hFF, 8'hFF, 8'hC0},
                  {8'hC0, 8'hC0, 8'hC0, 8'hC0}};
        vt[1] = '{14'd1234,  16'h1234, {8'hF9, 8'hA4, 8'hB0, 8'h99},
                  {8'hF9, 8'hA4, 8'hB0, 8'h99}};
        vt[2] = '{14'd405,   16'h0405, {8'hFF, 8'h99, 8'hC0, 8'h92},
                  {8'hC0, 8'h99, 8'hC0, 8'h92}};
        vt[3] = '{14'd12000, 16'h9999, {8'h90, 8'h90, 8'h90, 8'h90},
                  {8'h90, 8'h90, 8'h90, 8'h90}};
        vt[4] = '{14'd16383, 16'h9999, {8'h90, 8'h90, 8'h90, 8'h90},
                  {8'h90, 8'h90, 8'h90, 8'h90}};
        vt[5] = '{14'd7,     16'h0007, {8'hFF, 8'hFF, 8'hFF, 8'hF8},
                  {8'hC0, 8'hC0, 8'hC0, 8'hF8}};
        vt[6] = '{14'd1000,  16'h1000, {8'hF9, 8'hC0, 8'hC0, 8'hC0},
                  {8'hF9, 8'hC0, 8'hC0, 8'hC0}};
        vt[7] = '{14'd50,    16'h0050, {8'hFF, 8'hFF, 8'h92, 8'hC0},
                  {8'hC0, 8'hC0, 8'h92, 8'hC0}};

        // Reset state, asserted before any clock edge.
        rst   = 1'b1;
        value = 14'd0;
        #1;
        chk("rst_bcd", {16'h0, bcd_a}, 32'h0);
        chk("rst_seg", {24'h0, seg_a}, 32'hFF);
        chk("rst_an",  {28'h0, an_a},  32'hF);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Scan stepping with value 0: an changes every 4 cycles.
        for (int d = 0; d < 5; d++) begin
            @(negedge clk);
            chk("step_an", {28'h0, an_a},
                {28'h0, ~(4'b0001 << (d % 4))});
            chk("step_seg", {24'h0, seg_a},
                (d % 4 == 0) ? 32'hC0 : 32'hFF);
            if (d < 4) repeat (3) @(negedge clk);
        end
        chk("step_bcd", {16'h0, bcd_a}, 32'h0);

        for (int k = 0; k < 8; k++) begin
            value = vt[k].v;
            wait_bcd(vt[k].b);
            @(negedge clk);
            for (int d = 0; d < 4; d++) begin
                wait_an(~(4'b0001 << d));
                chk($sformatf("seg_a_v%0d_d%0d", k, d),
                    {24'h0, seg_a}, {24'h0, vt[k].sa[d]});
                chk($sformatf("seg_b_v%0d_d%0d", k, d),
                    {24'h0, seg_b}, {24'h0, vt[k].sb[d]});
            end
        end

        // Value change mid-SHIFT: old sample completes first.
        value = 14'd0;
        wait_bcd(16'h0000);
        value = 14'd1111;
        wait_bcd(16'h1111);
        value = 14'd0;
        wait_bcd(16'h0000);
        value = 14'd1111;
        repeat (5) @(negedge clk);
        value = 14'd2222;
        repeat (10) @(negedge clk);
        chk("mid_pre", {16'h0, bcd_a}, 32'h0);
        @(negedge clk);
        chk("mid_first", {16'h0, bcd_a}, 32'h1111);
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bcd_a != 16'h1111)
                chk("mid_hold", {16'h0, bcd_a}, 32'h1111);
        end
        chk("mid_hold_end", {16'h0, bcd_a}, 32'h1111);
        @(negedge clk);
        chk("mid_second", {16'h0, bcd_a}, 32'h2222);

        // Reset pulse during SHIFT aborts the conversion.
        value = 14'd1234;
        wait_bcd(16'h1234);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("ar_bcd", {16'h0, bcd_a}, 32'h0);
        chk("ar_seg", {24'h0, seg_a}, 32'hFF);
        chk("ar_an",  {28'h0, an_a},  32'hF);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rel_an",  {28'h0, an_a},  32'hE);
        chk("rel_seg", {24'h0, seg_a}, 32'hC0);
        repeat (14) @(negedge clk);
        chk("rel_hold", {16'h0, bcd_a}, 32'h0);
        @(negedge clk);
        chk("rel_conv", {16'h0, bcd_a}, 32'h1234);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
